// File: rtl/local_packet_fifo_if.sv
// Bundles the local-in packet FIFO's data, handshake and status signals.
// The master side is the local-in merge stage plus the neuron core. The
// slave side is the FIFO itself.
interface local_packet_fifo_if #(
  parameter int PACKET_WIDTH   = 12,
  parameter int ADDR_WIDTH     = 4,
  parameter int DROP_CNT_WIDTH = 8
);

  logic [PACKET_WIDTH-1:0]   din;
  logic                      din_wen;
  logic                      ren;
  logic                      clear_overflow;
  logic [PACKET_WIDTH-1:0]   dout;
  logic                      dout_valid;
  logic                      empty;
  logic                      full;
  logic [ADDR_WIDTH:0]       count;
  logic                      overflow;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  modport master (
    output din, din_wen, ren, clear_overflow,
    input  dout, dout_valid, empty, full, count, overflow, drop_count
  );

  modport slave (
    input  din, din_wen, ren, clear_overflow,
    output dout, dout_valid, empty, full, count, overflow, drop_count
  );

endinterface

// File: rtl/local_packet_fifo.sv
// Receive-side packet FIFO sitting after the router's local-in merge stage.
// The producer cannot be stalled. When the FIFO is full and no read frees a
// slot, incoming packets are dropped. Each drop sets a sticky overflow flag
// and bumps a saturating drop counter that software can inspect and clear.
module local_packet_fifo #(
  parameter int PACKET_WIDTH   = 12,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  local_packet_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [PACKET_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]     wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0]     rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]       count_q, count_d;
  logic [PACKET_WIDTH-1:0]   dout_q, dout_d;
  logic                      doutValid_q, doutValid_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] dropCount_q, dropCount_d;

  logic emptyInt;
  logic fullInt;
  logic rdAcc;
  logic wrAcc;
  logic dropHit;

  // Status flags come straight from the registered occupancy, so din and ren
  // never reach an output combinationally.
  assign emptyInt = (count_q == '0);
  assign fullInt  = (count_q == FULL_COUNT);

  // A read on a full FIFO frees a slot in the same cycle, so a simultaneous
  // write is still accepted. Only a write that finds no room becomes a drop.
  assign rdAcc   = bus.ren & ~emptyInt;
  assign wrAcc   = bus.din_wen & (~fullInt | rdAcc);
  assign dropHit = bus.din_wen & fullInt & ~rdAcc;

  // Compute next-state values for pointers, occupancy, read data and drop bookkeeping.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;
    overflow_d  = overflow_q;
    dropCount_d = dropCount_q;

    if (wrAcc) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end

    if (rdAcc) begin
      rdPtr_d     = rdPtr_q + 1'b1;
      dout_d      = mem_q[rdPtr_q];
      doutValid_d = 1'b1;
    end

    case ({wrAcc, rdAcc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins and leaves a count of one.
    if (dropHit) begin
      overflow_d = 1'b1;
      if (bus.clear_overflow) begin
        dropCount_d = DROP_CNT_WIDTH'(1);
      end else if (~&dropCount_q) begin
        dropCount_d = dropCount_q + 1'b1;
      end
    end else if (bus.clear_overflow) begin
      overflow_d  = 1'b0;
      dropCount_d = '0;
    end
  end

  // Write storage only when a packet is accepted. Reset ignores writes, and the contents themselves are never cleared.
  always_ff @(posedge clk) begin
    if (!reset && wrAcc) begin
      mem_q[wrPtr_q] <= bus.din;
    end
  end

  // Register all control state. Synchronous reset empties the FIFO and clears the overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      dropCount_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
      overflow_q  <= overflow_d;
      dropCount_q <= dropCount_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = doutValid_q;
  assign bus.empty      = emptyInt;
  assign bus.full       = fullInt;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = dropCount_q;

endmodule
